// File: rtl/jtframe_romrq_pkg.sv
// Shared types and helpers for the ROM request cache: FSM states, line
// index extraction and DW-wide slice selection out of a 32-bit SDRAM line.
package jtframe_romrq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    function automatic int lsb_bits(input int dw);
        return (dw == 8) ? 2 : (dw == 16) ? 1 : 0;
    endfunction

    function automatic logic [31:0] line_of(input logic [31:0] addr, input int dw);
        return addr >> lsb_bits(dw);
    endfunction

    // Lower byte/word addresses live in the low bits of the SDRAM line.
    function automatic logic [31:0] slice_of(input logic [31:0] data32,
                                             input logic [1:0]  addr_lsb,
                                             input int          dw);
        logic [31:0] s;
        s = data32;
        if (dw == 8) begin
            s = data32 >> {addr_lsb, 3'b000};
        end else if (dw == 16) begin
            s = data32 >> {addr_lsb[0], 4'b0000};
        end
        return s;
    endfunction

endpackage

// File: rtl/jtframe_romrq_line.sv
// One cache entry: tag, valid bit and a 32-bit SDRAM line, with a
// combinational match against the line currently requested by the game.
module jtframe_romrq_line
    import jtframe_romrq_pkg::*;
#(
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [LW-1:0] tag_i,
    input  logic [31:0]   data_i,
    input  logic [LW-1:0] line_i,
    output logic          match_o,
    output logic [31:0]   data_o
);

    logic [LW-1:0] tag_q;
    logic          valid_q;
    logic [31:0]   data_q;

    // A flush wins over a simultaneous load so an aborted fetch never lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
        end else if (clr_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            tag_q   <= tag_i;
            data_q  <= data_i;
            valid_q <= 1'b1;
        end
    end

    assign match_o = valid_q && (tag_q == line_i);
    assign data_o  = data_q;

endmodule

// File: rtl/jtframe_romrq_cache.sv
// Game-side SDRAM read initiator for one ROM region: a two-line cache in
// front of the framework request port, returning DW-wide slices.
module jtframe_romrq_cache
    import jtframe_romrq_pkg::*;
#(
    parameter int          AW     = 18,
    parameter int          DW     = 8,
    parameter logic [21:0] OFFSET = 22'h0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          downloading,
    input  logic          loop_rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    output logic [DW-1:0] dout,
    output logic          data_ok,
    output logic          sdram_req,
    input  logic          sdram_ack,
    output logic [21:0]   sdram_addr,
    input  logic [31:0]   data_read,
    input  logic          data_rdy
);

    localparam int LSB = lsb_bits(DW);
    localparam int LW  = AW - LSB;

    state_t        state_q, state_d;
    logic          req_q, req_d;
    logic [21:0]   saddr_q, saddr_d;
    logic [LW-1:0] line_q, line_d;
    logic          victim_q, victim_d;
    logic          data_ok_q, data_ok_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          fill;

    logic [LW-1:0] line_w;
    logic [1:0]    match;
    logic [1:0]    load;
    logic [31:0]   entry_data [2];
    logic          hit;
    logic [31:0]   hit_data;
    logic [DW-1:0] hit_slice;

    assign line_w = LW'(line_of(32'(addr), DW));
    assign load   = {fill & victim_q, fill & ~victim_q};

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        jtframe_romrq_line #(.LW(LW)) u_line (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (downloading),
            .load_i (load[gi]),
            .tag_i  (line_q),
            .data_i (data_read),
            .line_i (line_w),
            .match_o(match[gi]),
            .data_o (entry_data[gi])
        );
    end

    // Entry 0 has priority when both entries happen to match.
    assign hit       = cs && (match != 2'b00);
    assign hit_data  = match[0] ? entry_data[0] : entry_data[1];
    assign hit_slice = DW'(slice_of(hit_data, addr[1:0], DW));

    always_comb begin
        data_ok_d = hit && !downloading;
        dout_d    = data_ok_d ? hit_slice : dout_q;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        saddr_d  = saddr_q;
        line_d   = line_q;
        victim_d = victim_q;
        fill     = 1'b0;
        if (downloading) begin
            state_d = IDLE;
            req_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cs && !hit && !loop_rst) begin
                        line_d  = line_w;
                        saddr_d = OFFSET + 22'({line_w, 1'b0});
                        req_d   = 1'b1;
                        state_d = REQ;
                    end
                end
                REQ: begin
                    if (sdram_ack) begin
                        req_d = 1'b0;
                        // Controllers with zero read latency answer together with the ack.
                        if (data_rdy) begin
                            fill     = 1'b1;
                            victim_d = ~victim_q;
                            state_d  = IDLE;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (data_rdy) begin
                        fill     = 1'b1;
                        victim_d = ~victim_q;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            req_q     <= 1'b0;
            saddr_q   <= '0;
            line_q    <= '0;
            victim_q  <= 1'b0;
            data_ok_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            saddr_q   <= saddr_d;
            line_q    <= line_d;
            victim_q  <= victim_d;
            data_ok_q <= data_ok_d;
            dout_q    <= dout_d;
        end
    end

    assign dout       = dout_q;
    assign data_ok    = data_ok_q;
    assign sdram_req  = req_q;
    assign sdram_addr = saddr_q;

endmodule

// File: tb/tb_jtframe_romrq_cache.sv
// Bench for jtframe_romrq_cache: a byte-wide and a word-wide instance
// checked every cycle against a behavioural cache model plus literal checks.
module tb_jtframe_romrq_cache;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        downloading = 1'b0;
    logic        loop_rst = 1'b0;
    logic        cs8 = 1'b0;
    logic        cs16 = 1'b0;
    logic [17:0] addr = '0;
    logic        sdram_ack = 1'b0;
    logic        data_rdy = 1'b0;
    logic [31:0] data_read = '0;

    logic [7:0]  dout8;
    logic [15:0] dout16;
    logic        ok8, ok16, req8, req16;
    logic [21:0] saddr8, saddr16;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    jtframe_romrq_cache #(.AW(18), .DW(8), .OFFSET(22'h10000)) u8 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
        .cs(cs8), .addr(addr), .dout(dout8), .data_ok(ok8), .sdram_req(req8),
        .sdram_ack(sdram_ack), .sdram_addr(saddr8), .data_read(data_read), .data_rdy(data_rdy)
    );

    jtframe_romrq_cache #(.AW(18), .DW(16), .OFFSET(22'h3FFFFE)) u16 (
        .clk(clk), .rst_n(rst_n), .downloading(downloading), .loop_rst(loop_rst),
        .cs(cs16), .addr(addr), .dout(dout16), .data_ok(ok16), .sdram_req(req16),
        .sdram_ack(sdram_ack), .sdram_addr(saddr16), .data_read(data_read), .data_rdy(data_rdy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0: DW=8, index 1: DW=16) ----
    int          m_tag  [2][2];
    bit          m_val  [2][2];
    logic [31:0] m_data [2][2];
    bit          m_vic  [2];
    int          m_busy [2];   // 0 no fetch, 1 awaiting ack, 2 awaiting data
    int          m_pend [2];
    bit          e_req  [2];
    logic [21:0] e_addr [2];
    bit          e_ok   [2];
    logic [31:0] e_dout [2];

    function automatic int sh(input int k);
        return (k == 0) ? 2 : 1;
    endfunction

    function automatic logic [21:0] off(input int k);
        return (k == 0) ? 22'h10000 : 22'h3FFFFE;
    endfunction

    task automatic model_fill(input int k);
        m_tag[k][m_vic[k]]  = m_pend[k];
        m_data[k][m_vic[k]] = data_read;
        m_val[k][m_vic[k]]  = 1'b1;
        m_vic[k]            = ~m_vic[k];
        m_busy[k]           = 0;
    endtask

    task automatic model_step();
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                m_val[k][0] = 1'b0; m_val[k][1] = 1'b0; m_vic[k] = 1'b0;
                m_busy[k] = 0; e_req[k] = 1'b0; e_addr[k] = '0;
                e_ok[k] = 1'b0; e_dout[k] = '0;
            end
            return;
        end
        for (int k = 0; k < 2; k++) begin
            logic        c;
            int          ln;
            int          hw;
            logic [31:0] w;
            c  = (k == 0) ? cs8 : cs16;
            ln = int'(addr) >> sh(k);
            hw = -1;
            for (int e = 1; e >= 0; e--) if (m_val[k][e] && m_tag[k][e] == ln) hw = e;
            e_ok[k] = c && (hw >= 0) && !downloading;
            if (e_ok[k]) begin
                w = m_data[k][hw];
                e_dout[k] = (k == 0) ? ((w >> (8 * (addr % 4))) & 32'hFF)
                                     : ((w >> (16 * (addr % 2))) & 32'hFFFF);
            end
            if (downloading) begin
                m_val[k][0] = 1'b0; m_val[k][1] = 1'b0;
                m_busy[k] = 0; e_req[k] = 1'b0;
            end else if (m_busy[k] == 0) begin
                if (c && hw < 0 && !loop_rst) begin
                    m_busy[k] = 1; m_pend[k] = ln; e_req[k] = 1'b1;
                    e_addr[k] = off(k) + 22'(2 * ln);
                end
            end else if (m_busy[k] == 1) begin
                if (sdram_ack) begin
                    e_req[k] = 1'b0;
                    if (data_rdy) model_fill(k);
                    else m_busy[k] = 2;
                end
            end else if (data_rdy) begin
                model_fill(k);
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            chk("cmp_req8",    32'(req8),    32'(e_req[0]));
            chk("cmp_saddr8",  32'(saddr8),  32'(e_addr[0]));
            chk("cmp_ok8",     32'(ok8),     32'(e_ok[0]));
            chk("cmp_dout8",   32'(dout8),   e_dout[0]);
            chk("cmp_req16",   32'(req16),   32'(e_req[1]));
            chk("cmp_saddr16", 32'(saddr16), 32'(e_addr[1]));
            chk("cmp_ok16",    32'(ok16),    32'(e_ok[1]));
            chk("cmp_dout16",  32'(dout16),  e_dout[1]);
        end
    end

    // ---------------- stimulus helpers -------------------------------------
    task automatic tick();
        @(negedge clk);
    endtask

    // Controller stand-in: ack the pending request, then return data after lat cycles.
    task automatic respond(input logic [31:0] d, input int lat, input bit same);
        int n;
        n = 0;
        while (!(req8 || req16) && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL resp_timeout t=%0t actual=no_req required=req", $time);
            return;
        end
        sdram_ack = 1'b1;
        if (same) begin
            data_rdy  = 1'b1;
            data_read = d;
        end
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        if (!same) begin
            repeat (lat) tick();
            data_rdy  = 1'b1;
            data_read = d;
            tick();
            data_rdy  = 1'b0;
        end
    endtask

    task automatic wait_ok8(input string nm);
        int n;
        n = 0;
        while (!ok8 && n < 8) begin
            tick();
            n++;
        end
        chk({nm, "_ok"}, 32'(ok8), 32'd1);
    endtask

    task automatic access(input string nm, input logic [17:0] a, input logic [31:0] d,
                          input bit exp_miss, input logic [7:0] exp_dout);
        addr = a;
        cs8  = 1'b1;
        tick();
        chk({nm, "_req"}, 32'(req8), 32'(exp_miss));
        if (req8) respond(d, 2, 1'b0);
        wait_ok8(nm);
        chk({nm, "_dout"}, 32'(dout8), 32'(exp_dout));
        $display("txn %s addr=%h miss=%0d dout=%h", nm, a, exp_miss, dout8);
    endtask

    // ---------------- directed sequence ------------------------------------
    initial begin
        repeat (3) tick();
        chk("rst_dout8",  32'(dout8),  32'd0);
        chk("rst_ok8",    32'(ok8),    32'd0);
        chk("rst_req8",   32'(req8),   32'd0);
        chk("rst_saddr8", 32'(saddr8), 32'd0);
        chk("rst_ok16",   32'(ok16),   32'd0);
        chk("rst_req16",  32'(req16),  32'd0);
        rst_n = 1'b1;
        tick();

        // Cold miss, then a hit in the same line.
        addr = 18'h00005;
        cs8  = 1'b1;
        tick();
        chk("cold_req",  32'(req8),   32'd1);
        chk("cold_addr", 32'(saddr8), 32'h10002);
        respond(32'hDDCCBBAA, 1, 1'b0);
        chk("cold_ok_early", 32'(ok8), 32'd0);
        tick();
        chk("cold_ok",   32'(ok8),   32'd1);
        chk("cold_dout", 32'(dout8), 32'hBB);
        $display("txn cold_miss addr=%h dout=%h", addr, dout8);
        addr = 18'h00007;
        tick();
        chk("hit_req",  32'(req8),  32'd0);
        chk("hit_ok",   32'(ok8),   32'd1);
        chk("hit_dout", 32'(dout8), 32'hDD);
        $display("txn hit addr=%h dout=%h", addr, dout8);

        // Round-robin: line1 in entry0, line2 -> entry1, line3 -> entry0, line1 -> entry1.
        access("fill_l2",  18'h00008, 32'h44332211, 1'b1, 8'h11);
        access("fill_l3",  18'h0000C, 32'h88776655, 1'b1, 8'h55);
        access("hit_l2",   18'h00009, 32'h0,        1'b0, 8'h22);
        access("refill_l1",18'h00004, 32'hDDCCBBAA, 1'b1, 8'hAA);
        access("hit_l3",   18'h0000E, 32'h0,        1'b0, 8'h77);
        access("miss_l2",  18'h00008, 32'h44332211, 1'b1, 8'h11);

        // Word-wide instance: ack and data in the same cycle, then address wrap.
        cs8  = 1'b0;
        addr = 18'h00001;
        cs16 = 1'b1;
        tick();
        chk("sc_req",  32'(req16),   32'd1);
        chk("sc_addr", 32'(saddr16), 32'h3FFFFE);
        sdram_ack = 1'b1;
        data_rdy  = 1'b1;
        data_read = 32'h12345678;
        tick();
        sdram_ack = 1'b0;
        data_rdy  = 1'b0;
        chk("sc_req_drop", 32'(req16), 32'd0);
        tick();
        chk("sc_ok",   32'(ok16),   32'd1);
        chk("sc_dout", 32'(dout16), 32'h1234);
        $display("txn same_cycle addr=%h dout=%h", addr, dout16);
        addr = 18'h00002;
        tick();
        chk("wrap_req",  32'(req16),   32'd1);
        chk("wrap_addr", 32'(saddr16), 32'h000000);
        respond(32'hCAFEF00D, 0, 1'b0);
        tick();
        chk("wrap_ok",   32'(ok16),   32'd1);
        chk("wrap_dout", 32'(dout16), 32'hF00D);
        $display("txn wrap addr=%h dout=%h", addr, dout16);
        cs16 = 1'b0;

        // Download abort while waiting for data; a hit is also suppressed.
        addr = 18'h00040;
        cs8  = 1'b1;
        tick();
        chk("dl_req", 32'(req8), 32'd1);
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        tick();
        downloading = 1'b1;
        addr = 18'h00008;
        tick();
        downloading = 1'b0;
        cs8 = 1'b0;
        chk("dl_req_off", 32'(req8), 32'd0);
        chk("dl_ok_blocked", 32'(ok8), 32'd0);
        data_rdy  = 1'b1;
        data_read = 32'h0BADF00D;
        tick();
        data_rdy = 1'b0;
        tick();
        chk("dl_late_ok",  32'(ok8),  32'd0);
        chk("dl_late_req", 32'(req8), 32'd0);
        $display("txn download_abort addr=%h", addr);
        access("dl_flushed", 18'h00008, 32'h44332211, 1'b1, 8'h11);
        access("dl_refetch", 18'h00040, 32'h5A5A5AA5, 1'b1, 8'hA5);

        // loop_rst blocks new requests but not an outstanding one.
        addr     = 18'h00100;
        loop_rst = 1'b1;
        repeat (3) begin
            tick();
            chk("lr_block", 32'(req8), 32'd0);
        end
        loop_rst = 1'b0;
        tick();
        chk("lr_req",  32'(req8),   32'd1);
        chk("lr_addr", 32'(saddr8), 32'h10080);
        loop_rst = 1'b1;
        respond(32'h01020304, 1, 1'b0);
        wait_ok8("lr");
        chk("lr_dout", 32'(dout8), 32'h04);
        loop_rst = 1'b0;
        $display("txn loop_rst addr=%h dout=%h", addr, dout8);

        // Asynchronous reset in the middle of a request.
        addr = 18'h00200;
        tick();
        chk("ar_req", 32'(req8), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_req0",   32'(req8),   32'd0);
        chk("ar_saddr0", 32'(saddr8), 32'd0);
        chk("ar_dout0",  32'(dout8),  32'd0);
        chk("ar_ok0",    32'(ok8),    32'd0);
        tick();
        rst_n = 1'b1;
        cs8   = 1'b0;
        tick();
        $display("txn async_reset");
        access("ar_miss", 18'h00007, 32'hDDCCBBAA, 1'b1, 8'hDD);
        cs8 = 1'b0;
        repeat (2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "bench timeout");
    end

endmodule
